// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: SPI pins plus local TX/RX/status strobes of the SPI responder port.
interface spi_slave_port_if #(parameter int DATA_W = 8);
    logic SCK, SS_N, MOSI, MISO, MISO_OE;
    logic SENDER_WRITE, RECEIVER_READ, STATUS_CLR;
    logic [DATA_W-1:0] DATA_IN, DATA_OUT;
    logic [7:0] STATUS;
    modport master (
        output SCK, SS_N, MOSI, DATA_IN, SENDER_WRITE, RECEIVER_READ, STATUS_CLR,
        input MISO, MISO_OE, DATA_OUT, STATUS
    );
    modport slave (
        input SCK, SS_N, MOSI, DATA_IN, SENDER_WRITE, RECEIVER_READ, STATUS_CLR,
        output MISO, MISO_OE, DATA_OUT, STATUS
    );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: mode-0 SPI responder oversampled in S_CLK, one-byte TX and RX holding registers.
module spi_slave_port #(
    parameter int DATA_W = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic S_CLK,
    input logic CLR,
    spi_slave_port_if.slave bus
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
    logic sck_d, ss_d, oe, reload, tx_full, rx_full;
    logic underrun, frame_err, collision, overrun;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] tx_shift, tx_hold, data_out, rx_next;
    logic [DATA_W-2:0] rx_shift;
    logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s, reload_now, complete;
    // SS_N chain resets low so a select held across CLR cannot fake an ss_fall
    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            sck_q <= '0;
            ss_q <= '0;
            mosi_q <= '0;
            sck_d <= 1'b0;
            ss_d <= 1'b0;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-2:0], bus.SCK};
            ss_q <= {ss_q[SYNC_STAGES-2:0], bus.SS_N};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
            sck_d <= sck_q[SYNC_STAGES-1];
            ss_d <= ss_q[SYNC_STAGES-1];
        end
    end
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
    assign ss_fall = ~ss_q[SYNC_STAGES-1] & ss_d;
    assign ss_rise = ss_q[SYNC_STAGES-1] & ~ss_d;
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign rx_next = {rx_shift, mosi_s};
    assign reload_now = !ss_rise && (state == LOAD || (state == SHIFT && sck_fall && reload));
    assign complete = !ss_rise && state == SHIFT && sck_rise && bit_cnt == LAST;
    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            oe <= 1'b0;
            reload <= 1'b0;
            bit_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            tx_hold <= '0;
            tx_full <= 1'b0;
            data_out <= '0;
            rx_full <= 1'b0;
            underrun <= 1'b0;
            frame_err <= 1'b0;
            collision <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= ss_rise ? IDLE : (state == IDLE && ss_fall) ? LOAD : (state == LOAD) ? SHIFT : state;
            oe <= ss_rise ? 1'b0 : (state == LOAD) ? 1'b1 : oe;
            reload <= (ss_rise || state != SHIFT) ? 1'b0 : complete ? 1'b1 : sck_fall ? 1'b0 : reload;
            bit_cnt <= (ss_rise || state != SHIFT) ? '0 : sck_rise ? (bit_cnt == LAST ? '0 : bit_cnt + 1'b1) : bit_cnt;
            tx_shift <= reload_now ? (tx_full ? tx_hold : '1) : (state == SHIFT && sck_fall) ? tx_shift << 1 : tx_shift;
            rx_shift <= (state == SHIFT && sck_rise) ? rx_next[DATA_W-2:0] : rx_shift;
            // a write in a reload cycle lands after the shifter has taken the old byte
            tx_hold <= (bus.SENDER_WRITE && (!tx_full || reload_now)) ? bus.DATA_IN : tx_hold;
            tx_full <= bus.SENDER_WRITE ? 1'b1 : reload_now ? 1'b0 : tx_full;
            data_out <= (complete && (!rx_full || bus.RECEIVER_READ)) ? rx_next : data_out;
            rx_full <= complete ? 1'b1 : bus.RECEIVER_READ ? 1'b0 : rx_full;
            underrun <= (reload_now && !tx_full) | (underrun & ~bus.STATUS_CLR);
            frame_err <= (ss_rise && bit_cnt != '0) | (frame_err & ~bus.STATUS_CLR);
            collision <= (bus.SENDER_WRITE && tx_full && !reload_now) | (collision & ~bus.STATUS_CLR);
            overrun <= (complete && rx_full && !bus.RECEIVER_READ) | (overrun & ~bus.STATUS_CLR);
        end
    end
    assign bus.MISO = oe ? tx_shift[DATA_W-1] : 1'b1;
    assign bus.MISO_OE = oe;
    assign bus.DATA_OUT = data_out;
    assign bus.STATUS = {1'b0, overrun, state == IDLE, ~tx_full, collision, rx_full, frame_err, underrun};
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed and random SPI frames against a byte-level model of the responder.
module tb_spi_slave_port;
    localparam int DW = 8, SYNC = 2, HP = 4;
    logic clk = 1'b0, rst = 1'b1;
    int n_run = 0, n_fail = 0;
    logic m_tx_full, m_rx_full, m_un, m_fe, m_col, m_ov;
    logic [7:0] m_tx_hold, m_data_out, a, c;
    spi_slave_port_if #(.DATA_W(DW)) bus ();
    spi_slave_port #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (.S_CLK(clk), .CLR(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {1'b0, m_ov, 1'b1, ~m_tx_full, m_col, m_rx_full, m_fe, m_un};
    endfunction

    task automatic m_reset();
        {m_tx_full, m_rx_full, m_un, m_fe, m_col, m_ov} = '0;
        m_tx_hold = '0;
        m_data_out = '0;
    endtask

    task automatic m_load(output logic [7:0] b);
        b = m_tx_full ? m_tx_hold : 8'hFF;
        if (!m_tx_full) m_un = 1'b1;
        m_tx_full = 1'b0;
    endtask

    task automatic m_write(input logic [7:0] d);
        if (m_tx_full) m_col = 1'b1;
        else begin
            m_tx_hold = d;
            m_tx_full = 1'b1;
        end
    endtask

    task automatic m_rx(input logic [7:0] b, input bit rd);
        if (m_rx_full && !rd) m_ov = 1'b1;
        else begin
            m_data_out = b;
            m_rx_full = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        bus.DATA_IN = d;
        bus.SENDER_WRITE = 1'b1;
        tick(1);
        bus.SENDER_WRITE = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] d);
        pulse_wr(d);
        m_write(d);
    endtask

    task automatic host_read();
        bus.RECEIVER_READ = 1'b1;
        tick(1);
        bus.RECEIVER_READ = 1'b0;
        m_rx_full = 1'b0;
    endtask

    task automatic host_clr();
        bus.STATUS_CLR = 1'b1;
        tick(1);
        bus.STATUS_CLR = 1'b0;
        {m_un, m_fe, m_col, m_ov} = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_status"}, 32'(bus.STATUS), 32'(m_status()));
        check({tag, "_data"}, 32'(bus.DATA_OUT), 32'(m_data_out));
    endtask

    // mo is left-aligned MOSI data; the frame ends with SCK still high so no trailing reload
    task automatic spi_frame(input string tag, input logic [31:0] mo, input int nbits,
                             input bit mid_wr, input logic [7:0] wd, input bit rd_last);
        logic [31:0] got, exp, mask;
        logic [7:0] b;
        int nfull;
        bit w;
        got = '0;
        exp = '0;
        nfull = nbits / 8;
        w = mid_wr && nbits > 3;
        m_load(b);
        exp[31 -: 8] = b;
        if (w) m_write(wd);
        for (int j = 0; j < nfull; j++) begin
            m_rx(mo[31 - 8*j -: 8], rd_last && j == nfull - 1);
            if (8*(j+1) < nbits) begin
                m_load(b);
                exp[23 - 8*j -: 8] = b;
            end
        end
        if (nbits % 8 != 0) m_fe = 1'b1;
        mask = ~(32'hFFFF_FFFF >> nbits);
        bus.SS_N = 1'b0;
        bus.MOSI = mo[31];
        tick(6);
        for (int k = 0; k < nbits; k++) begin
            bus.MOSI = mo[31 - k];
            tick(HP);
            bus.SCK = 1'b1;
            got[31 - k] = bus.MISO;
            if (rd_last && k == nbits - 1) begin
                tick(SYNC);
                bus.RECEIVER_READ = 1'b1;
                tick(1);
                bus.RECEIVER_READ = 1'b0;
                tick(HP - SYNC - 1);
            end else if (w && k == 3) begin
                tick(1);
                pulse_wr(wd);
                tick(HP - 2);
            end else tick(HP);
            if (k < nbits - 1) bus.SCK = 1'b0;
        end
        bus.SS_N = 1'b1;
        tick(6);
        bus.SCK = 1'b0;
        tick(4);
        check({tag, "_miso"}, got & mask, exp & mask);
        check_state(tag);
    endtask

    initial begin
        int op, nb;
        bus.SCK = 1'b0;
        bus.SS_N = 1'b1;
        bus.MOSI = 1'b0;
        bus.DATA_IN = '0;
        bus.SENDER_WRITE = 1'b0;
        bus.RECEIVER_READ = 1'b0;
        bus.STATUS_CLR = 1'b0;
        m_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_status", 32'(bus.STATUS), 32'h30);
        check("rst_oe", 32'(bus.MISO_OE), 32'h0);
        check("rst_miso", 32'(bus.MISO), 32'h1);
        check("rst_data", 32'(bus.DATA_OUT), 32'h0);

        host_write(8'hA5);
        spi_frame("single", {8'h3C, 24'h0}, 8, 1'b0, 8'h00, 1'b0);
        check("single_data_k", 32'(bus.DATA_OUT), 32'h3C);
        check("single_status_k", 32'(bus.STATUS), 32'h34);
        host_read();
        check("single_read_k", 32'(bus.STATUS), 32'h30);

        host_write(8'h11);
        spi_frame("b2b", {8'h5A, 8'hC3, 16'h0}, 16, 1'b1, 8'h22, 1'b0);
        check("b2b_status_k", 32'(bus.STATUS), 32'h74);
        check("b2b_data_k", 32'(bus.DATA_OUT), 32'h5A);
        host_read();
        host_clr();
        check_state("b2b_clr");

        spi_frame("under", {8'($urandom), 24'h0}, 8, 1'b0, 8'h00, 1'b0);
        check("under_status_k", 32'(bus.STATUS), 32'h35);
        host_read();
        host_clr();

        a = 8'($urandom);
        c = 8'($urandom);
        host_write(a);
        host_write(c);
        check("col_status_k", 32'(bus.STATUS), 32'h28);
        spi_frame("col", {8'($urandom), 24'h0}, 8, 1'b0, 8'h00, 1'b0);
        host_read();
        host_clr();

        host_write(8'($urandom));
        spi_frame("ferr", $urandom, 5, 1'b0, 8'h00, 1'b0);
        check("ferr_status_k", 32'(bus.STATUS), 32'h32);
        host_clr();
        check("ferr_clr_k", 32'(bus.STATUS), 32'h30);

        a = 8'($urandom);
        c = 8'($urandom);
        host_write(8'($urandom));
        spi_frame("sim_a", {a, 24'h0}, 8, 1'b0, 8'h00, 1'b0);
        host_write(8'($urandom));
        spi_frame("sim_b", {c, 24'h0}, 8, 1'b0, 8'h00, 1'b1);
        check("sim_status_k", 32'(bus.STATUS), 32'h34);
        check("sim_data_k", 32'(bus.DATA_OUT), 32'(c));

        bus.SS_N = 1'b0;
        tick(6);
        repeat (3) begin
            bus.MOSI = 1'($urandom);
            tick(HP);
            bus.SCK = 1'b1;
            tick(HP);
            bus.SCK = 1'b0;
        end
        tick(1);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("clr_status", 32'(bus.STATUS), 32'h30);
        check("clr_oe", 32'(bus.MISO_OE), 32'h0);
        check("clr_miso", 32'(bus.MISO), 32'h1);
        check("clr_data", 32'(bus.DATA_OUT), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            bus.MOSI = 1'($urandom);
            tick(HP);
            bus.SCK = 1'b1;
            tick(HP);
            bus.SCK = 1'b0;
        end
        bus.SS_N = 1'b1;
        tick(8);
        check_state("clr_after");

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: host_write(8'($urandom));
                1: host_read();
                2: host_clr();
                default: begin
                    nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 23)) : 8 * int'($urandom_range(1, 3));
                    spi_frame("rnd", $urandom, nb, 1'($urandom_range(0, 1)), 8'($urandom),
                              (nb % 8 == 0) && ($urandom_range(0, 3) == 0));
                end
            endcase
            check_state("rnd_op");
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
